// File: rtl/conv_pw_accum_requant_if.sv
// Bus bundle for the pointwise accumulate/requant stage: control, input stream,
// weight and bias/scale read ports, output stream and status.
interface conv_pw_accum_requant_if #(
    parameter int IN_CH       = 16,
    parameter int OUT_CH      = 32,
    parameter int PAR_OC      = 4,
    parameter int BIAS_WIDTH  = 32,
    parameter int SCALE_WIDTH = 16
);
    localparam int GRPS  = OUT_CH / PAR_OC;
    localparam int GRP_W = (GRPS > 1) ? $clog2(GRPS) : 1;
    localparam int WA_W  = (GRPS * IN_CH > 1) ? $clog2(GRPS * IN_CH) : 1;

    logic                          start;
    logic [15:0]                   pix_count;
    logic [1:0]                    act_mode;
    // Streams: a beat transfers on the rising edge where valid && ready; a
    // producer holds valid and its payload stable until that edge.
    logic                          in_valid;
    logic                          in_ready;
    logic [7:0]                    in_data;
    logic                          wt_rd_en;
    logic [WA_W-1:0]               wt_addr;
    logic [PAR_OC*8-1:0]           wt_data;
    logic                          bs_rd_en;
    logic [GRP_W-1:0]              bs_addr;
    logic [PAR_OC*BIAS_WIDTH-1:0]  bias_data;
    logic [PAR_OC*SCALE_WIDTH-1:0] scale_data;
    logic                          out_valid;
    logic                          out_ready;
    logic [PAR_OC*8-1:0]           out_data;
    logic [GRP_W-1:0]              out_grp;
    logic                          busy;
    logic                          done;
    logic [2:0]                    state;

    modport master (
        output start, pix_count, act_mode, in_valid, in_data, wt_data,
               bias_data, scale_data, out_ready,
        input  in_ready, wt_rd_en, wt_addr, bs_rd_en, bs_addr, out_valid,
               out_data, out_grp, busy, done, state
    );

    modport slave (
        input  start, pix_count, act_mode, in_valid, in_data, wt_data,
               bias_data, scale_data, out_ready,
        output in_ready, wt_rd_en, wt_addr, bs_rd_en, bs_addr, out_valid,
               out_data, out_grp, busy, done, state
    );
endinterface

// File: rtl/conv_pw_accum_requant.sv
// Pointwise 1x1 conv: buffers one pixel's channels, runs PAR_OC dot products per
// output group, then bias, Q-format scale, activation and int8 saturation.
module conv_pw_accum_requant #(
    parameter int IN_CH       = 16,
    parameter int OUT_CH      = 32,
    parameter int PAR_OC      = 4,
    parameter int ACC_WIDTH   = 32,
    parameter int BIAS_WIDTH  = 32,
    parameter int SCALE_WIDTH = 16,
    parameter int SCALE_FRAC  = 8,
    parameter int RELU6_MAX   = 96
) (
    input logic                     clk,
    input logic                     rst,
    conv_pw_accum_requant_if.slave  bus
);
    localparam int GRPS  = OUT_CH / PAR_OC;
    localparam int GRP_W = (GRPS > 1) ? $clog2(GRPS) : 1;
    localparam int WA_W  = (GRPS * IN_CH > 1) ? $clog2(GRPS * IN_CH) : 1;
    localparam int IDX_W = (IN_CH > 1) ? $clog2(IN_CH) : 1;
    localparam int CNT_W = $clog2(IN_CH + 1);
    localparam int TW    = ACC_WIDTH + SCALE_WIDTH + 1;

    localparam logic signed [TW-1:0] RND    = TW'(2 ** (SCALE_FRAC - 1));
    localparam logic signed [TW-1:0] SAT_HI = TW'(127);
    localparam logic signed [TW-1:0] SAT_LO = TW'(-128);
    localparam logic signed [TW-1:0] R6_HI  = TW'(RELU6_MAX);
    localparam logic signed [TW-1:0] ZERO   = '0;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_MAC  = 3'd2,
        S_REQ  = 3'd3,
        S_OUT  = 3'd4,
        S_FIN  = 3'd5
    } state_t;

    state_t state, state_nx;

    logic [15:0]                  pix_left;
    logic [1:0]                   mode;
    logic [IDX_W-1:0]             ch;
    logic [CNT_W-1:0]             cnt;
    logic [GRP_W-1:0]             grp;
    logic [7:0]                   pixbuf  [IN_CH];
    logic [ACC_WIDTH-1:0]         acc     [PAR_OC];
    logic [BIAS_WIDTH-1:0]        bias_r  [PAR_OC];
    logic [SCALE_WIDTH-1:0]       scale_r [PAR_OC];
    logic [PAR_OC*8-1:0]          out_data_r;
    logic                         out_valid_r;

    logic                         in_ready, wt_rd_en, bs_rd_en, busy, done;
    logic [WA_W-1:0]              wt_addr;
    logic [GRP_W-1:0]             bs_addr;
    logic [IDX_W-1:0]             kidx;
    logic [15:0]                  prod    [PAR_OC];
    logic [ACC_WIDTH-1:0]         mac_term[PAR_OC];
    logic [PAR_OC*8-1:0]          req_result;

    function automatic logic [7:0] requant(
        input logic [ACC_WIDTH-1:0]   a,
        input logic [BIAS_WIDTH-1:0]  b,
        input logic [SCALE_WIDTH-1:0] s,
        input logic [1:0]             m
    );
        logic signed [TW-1:0] sum, t, y;
        sum = {{(TW-ACC_WIDTH){a[ACC_WIDTH-1]}}, a} + {{(TW-BIAS_WIDTH){b[BIAS_WIDTH-1]}}, b};
        t   = sum * {{(TW-SCALE_WIDTH){s[SCALE_WIDTH-1]}}, s};
        y   = (t + RND) >>> SCALE_FRAC;
        // Modes 1 and 3 are both plain ReLU; mode 2 additionally clamps high.
        if (m != 2'd0 && y < ZERO) y = ZERO;
        if (m == 2'd2 && y > R6_HI) y = R6_HI;
        if (y > SAT_HI) y = SAT_HI;
        if (y < SAT_LO) y = SAT_LO;
        return y[7:0];
    endfunction

    // Weight data for MAC step k arrives one cycle after its read, so it pairs
    // with pixbuf[cnt-1].
    always_comb begin
        kidx = IDX_W'(cnt - CNT_W'(1));
        for (int l = 0; l < PAR_OC; l++) begin
            prod[l] = {{8{pixbuf[kidx][7]}}, pixbuf[kidx]} *
                      {{8{bus.wt_data[8*l+7]}}, bus.wt_data[8*l +: 8]};
            mac_term[l] = {{(ACC_WIDTH-16){prod[l][15]}}, prod[l]};
            req_result[8*l +: 8] = requant(acc[l], bias_r[l], scale_r[l], mode);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        in_ready = 1'b0;
        wt_rd_en = 1'b0;
        wt_addr  = '0;
        bs_rd_en = 1'b0;
        bs_addr  = '0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.start) state_nx = (bus.pix_count == 16'd0) ? S_FIN : S_LOAD;
            end
            S_LOAD: begin
                busy     = 1'b1;
                in_ready = 1'b1;
                if (bus.in_valid && ch == IDX_W'(IN_CH - 1)) state_nx = S_MAC;
            end
            S_MAC: begin
                busy = 1'b1;
                if (cnt < CNT_W'(IN_CH)) begin
                    wt_rd_en = 1'b1;
                    wt_addr  = WA_W'(int'(grp) * IN_CH + int'(cnt));
                end
                if (cnt == '0) begin
                    bs_rd_en = 1'b1;
                    bs_addr  = grp;
                end
                if (cnt == CNT_W'(IN_CH)) state_nx = S_REQ;
            end
            S_REQ: begin
                busy     = 1'b1;
                state_nx = S_OUT;
            end
            S_OUT: begin
                busy = 1'b1;
                if (bus.out_ready) begin
                    if (grp != GRP_W'(GRPS - 1)) state_nx = S_MAC;
                    else if (pix_left == 16'd1)  state_nx = S_FIN;
                    else                         state_nx = S_LOAD;
                end
            end
            S_FIN: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pix_left    <= '0;
            mode        <= '0;
            ch          <= '0;
            cnt         <= '0;
            grp         <= '0;
            out_data_r  <= '0;
            out_valid_r <= 1'b0;
            for (int i = 0; i < IN_CH; i++) pixbuf[i] <= '0;
            for (int l = 0; l < PAR_OC; l++) begin
                acc[l]     <= '0;
                bias_r[l]  <= '0;
                scale_r[l] <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        pix_left <= bus.pix_count;
                        mode     <= bus.act_mode;
                        grp      <= '0;
                        ch       <= '0;
                    end
                end
                S_LOAD: begin
                    if (bus.in_valid) begin
                        pixbuf[ch] <= bus.in_data;
                        if (ch == IDX_W'(IN_CH - 1)) begin
                            ch  <= '0;
                            cnt <= '0;
                            for (int l = 0; l < PAR_OC; l++) acc[l] <= '0;
                        end else begin
                            ch <= ch + IDX_W'(1);
                        end
                    end
                end
                S_MAC: begin
                    cnt <= cnt + CNT_W'(1);
                    if (cnt != '0) begin
                        for (int l = 0; l < PAR_OC; l++) acc[l] <= acc[l] + mac_term[l];
                    end
                    if (cnt == CNT_W'(1)) begin
                        for (int l = 0; l < PAR_OC; l++) begin
                            bias_r[l]  <= bus.bias_data[BIAS_WIDTH*l +: BIAS_WIDTH];
                            scale_r[l] <= bus.scale_data[SCALE_WIDTH*l +: SCALE_WIDTH];
                        end
                    end
                end
                S_REQ: begin
                    out_data_r  <= req_result;
                    out_valid_r <= 1'b1;
                end
                S_OUT: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        cnt         <= '0;
                        for (int l = 0; l < PAR_OC; l++) acc[l] <= '0;
                        if (grp == GRP_W'(GRPS - 1)) begin
                            grp      <= '0;
                            pix_left <= pix_left - 16'd1;
                        end else begin
                            grp <= grp + GRP_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.wt_rd_en  = wt_rd_en;
    assign bus.wt_addr   = wt_addr;
    assign bus.bs_rd_en  = bs_rd_en;
    assign bus.bs_addr   = bs_addr;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_grp   = grp;
    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.state     = state;
endmodule
